// File: rtl/acc_pkg.sv
// Shared types and helpers for the sequential matrix-multiply accelerator.
// Holds the FSM state type, the accumulator width rule and the output clamp/wrap.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } acc_state_e;

    function automatic int acc_width(input int dat, input int n);
        return 2 * dat + $clog2(n) + 1;
    endfunction

    // Values are carried as 64 bits; callers keep the low out_size bits.
    function automatic logic [63:0] sat_trunc(
        input logic [63:0] value,
        input int          out_size,
        input bit          saturate
    );
        logic [63:0] lim;
        lim = (64'd1 << out_size) - 64'd1;
        if (saturate && (value > lim)) begin
            return lim;
        end
        return value & lim;
    endfunction

endpackage

// File: rtl/acc_mac_lane.sv
// One multiply-accumulate lane with a registered accumulator.
// acc_o is the next accumulator value, so write-back sees the final sum.
module acc_mac_lane
    import acc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = acc_width(DW, 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [AW-1:0] acc_o
);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + AW'(a_i) * AW'(b_i);
        end
    end

    assign acc_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_acc_seq.sv
// Sequential N x N matrix multiply / multiply-accumulate with LANES MAC lanes.
// Iterates row i, column group jb, then k; writes C on the last k of each group.
module matmul_acc_seq
    import acc_pkg::*;
#(
    parameter int DAT_SIZE = 8,
    parameter int MAT_SIZE = 2,
    parameter int OUT_SIZE = 8,
    parameter int LANES    = 1,
    parameter int SATURATE = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic                                        acc_mode,
    input  logic                                        clear,
    output logic                                        busy,
    output logic                                        done,
    input  logic [MAT_SIZE*MAT_SIZE-1:0][DAT_SIZE-1:0] acc_in_A,
    input  logic [MAT_SIZE*MAT_SIZE-1:0][DAT_SIZE-1:0] acc_in_B,
    output logic [MAT_SIZE*MAT_SIZE-1:0][OUT_SIZE-1:0] acc_out
);

    localparam int N   = MAT_SIZE;
    localparam int NN  = N * N;
    localparam int JBN = N / LANES;
    localparam int AW  = acc_width(DAT_SIZE, N);
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int BW  = (JBN > 1) ? $clog2(JBN) : 1;
    localparam int XW  = (NN > 1) ? $clog2(NN) : 1;

    acc_state_e                     state_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           mode_q;
    logic [CW-1:0]                  i_q;
    logic [CW-1:0]                  k_q;
    logic [BW-1:0]                  jb_q;
    logic [NN-1:0][OUT_SIZE-1:0]    c_q;
    logic [NN-1:0][OUT_SIZE-1:0]    c_d;

    logic [DAT_SIZE-1:0]            a_el;
    logic [LANES-1:0][DAT_SIZE-1:0] b_el;
    logic [LANES-1:0][AW-1:0]       lane_acc;
    logic [LANES-1:0][XW-1:0]       wb_idx;
    logic                           run;
    logic                           k_last;
    logic                           last;

    assign run    = (state_q == RUN);
    assign k_last = (k_q == CW'(N - 1));
    assign last   = run && k_last && (i_q == CW'(N - 1))
                    && (jb_q == BW'(JBN - 1));

    always_comb begin
        a_el = acc_in_A[XW'(int'(i_q) * N + int'(k_q))];
        for (int l = 0; l < LANES; l++) begin
            b_el[l]   = acc_in_B[XW'(int'(k_q) * N + int'(jb_q) * LANES + l)];
            wb_idx[l] = XW'(int'(i_q) * N + int'(jb_q) * LANES + l);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        acc_mac_lane #(
            .DW (DAT_SIZE),
            .AW (AW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (run),
            .clr_i (run && k_last),
            .a_i   (a_el),
            .b_i   (b_el[l]),
            .acc_o (lane_acc[l])
        );
    end

    // Clear beats start in IDLE; write-back adds old C only in accumulate mode.
    always_comb begin
        c_d = c_q;
        if ((state_q == IDLE) && clear) begin
            c_d = '0;
        end else if (run && k_last) begin
            for (int l = 0; l < LANES; l++) begin
                c_d[wb_idx[l]] = OUT_SIZE'(sat_trunc(
                    64'(lane_acc[l])
                    + (mode_q ? 64'(c_q[wb_idx[l]]) : 64'd0),
                    OUT_SIZE, SATURATE != 0));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            i_q     <= '0;
            k_q     <= '0;
            jb_q    <= '0;
            c_q     <= '0;
        end else begin
            c_q    <= c_d;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !clear) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        mode_q  <= acc_mode;
                        i_q     <= '0;
                        k_q     <= '0;
                        jb_q    <= '0;
                    end
                end
                RUN: begin
                    if (k_last) begin
                        k_q <= '0;
                        if (jb_q == BW'(JBN - 1)) begin
                            jb_q <= '0;
                            i_q  <= i_q + CW'(1);
                        end else begin
                            jb_q <= jb_q + BW'(1);
                        end
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_out = c_q;

endmodule

// File: tb/tb_matmul_acc_seq.sv
// Scoreboard bench: three configurations share stimulus, each has its own queue.
// u0 default, u1 wrapping (SATURATE=0), u2 two lanes.
module tb_matmul_acc_seq;

    typedef logic [3:0][7:0] mat_t;
    typedef struct {
        mat_t c;
        int   lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       acc_mode;
    logic       clear;
    mat_t       a_m;
    mat_t       b_m;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    mat_t       out_v [3];

    exp_t       sb [3][$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc  [3] = '{0, 0, 0};
    int         bcnt [3] = '{0, 0, 0};
    logic       pbusy [3] = '{1'b0, 1'b0, 1'b0};

    matmul_acc_seq #(
        .DAT_SIZE(8), .MAT_SIZE(2), .OUT_SIZE(8), .LANES(1), .SATURATE(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
        .clear(clear), .busy(busy_v[0]), .done(done_v[0]),
        .acc_in_A(a_m), .acc_in_B(b_m), .acc_out(out_v[0])
    );

    matmul_acc_seq #(
        .DAT_SIZE(8), .MAT_SIZE(2), .OUT_SIZE(8), .LANES(1), .SATURATE(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
        .clear(clear), .busy(busy_v[1]), .done(done_v[1]),
        .acc_in_A(a_m), .acc_in_B(b_m), .acc_out(out_v[1])
    );

    matmul_acc_seq #(
        .DAT_SIZE(8), .MAT_SIZE(2), .OUT_SIZE(8), .LANES(2), .SATURATE(1)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
        .clear(clear), .busy(busy_v[2]), .done(done_v[2]),
        .acc_in_A(a_m), .acc_in_B(b_m), .acc_out(out_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mat_t mk(input int e0, input int e1,
                                input int e2, input int e3);
        mat_t m;
        m[0] = 8'(e0);
        m[1] = 8'(e1);
        m[2] = 8'(e2);
        m[3] = 8'(e3);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic push(input mat_t c0, input mat_t c1, input mat_t c2,
                        input int l01, input int l2);
        sb[0].push_back('{c: c0, lat: l01});
        sb[1].push_back('{c: c1, lat: l01});
        sb[2].push_back('{c: c2, lat: l2});
    endtask

    task automatic run(input logic m);
        acc_mode = m;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    // Monitor: cyc=1 is the first busy cycle after the start edge.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            exp_t e;
            if (busy_v[u] && !pbusy[u]) begin
                cyc[u]  = 1;
                bcnt[u] = 1;
            end else begin
                cyc[u]++;
                if (busy_v[u]) bcnt[u]++;
            end
            if (done_v[u]) begin
                checks++;
                if (sb[u].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done u%0d got=1 want=0", u);
                end else begin
                    e = sb[u].pop_front();
                    if (out_v[u] !== e.c) begin
                        failures++;
                        $display("FAIL result u%0d got=%h want=%h",
                                 u, out_v[u], e.c);
                    end
                    checks++;
                    if (cyc[u] != e.lat) begin
                        failures++;
                        $display("FAIL done_cycle u%0d got=%0d want=%0d",
                                 u, cyc[u], e.lat);
                    end
                    checks++;
                    if (bcnt[u] != e.lat - 1) begin
                        failures++;
                        $display("FAIL busy_cycles u%0d got=%0d want=%0d",
                                 u, bcnt[u], e.lat - 1);
                    end
                end
            end
            pbusy[u] = busy_v[u];
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        mat_t base_a, base_b, basic, accum, all255, all2;
        base_a = mk(1, 2, 3, 4);
        base_b = mk(5, 6, 7, 8);
        basic  = mk(19, 22, 43, 50);
        accum  = mk(38, 44, 86, 100);
        all255 = mk(255, 255, 255, 255);
        all2   = mk(2, 2, 2, 2);

        rst_n = 1'b0; start = 1'b0; acc_mode = 1'b0; clear = 1'b0;
        a_m = '0; b_m = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        for (int u = 0; u < 3; u++) chk("rst_out", out_v[u], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        a_m = base_a; b_m = base_b;
        push(basic, basic, basic, 9, 5);
        run(1'b0);

        push(accum, accum, accum, 9, 5);
        run(1'b1);
        acc_mode = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int u = 0; u < 3; u++) chk("clear_out", out_v[u], 32'd0);

        a_m = all255; b_m = all255;
        push(all255, all2, all255, 9, 5);
        run(1'b0);

        // Abort a run with asynchronous reset in its third cycle.
        a_m = base_a; b_m = base_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_v), 32'd0);
        chk("abort_done", 32'(done_v), 32'd0);
        for (int u = 0; u < 3; u++) chk("abort_out", out_v[u], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        push(basic, basic, basic, 9, 5);
        run(1'b0);

        // start and clear during RUN must both be ignored.
        push(accum, accum, accum, 9, 5);
        acc_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        acc_mode = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_requeue_busy", 32'(busy_v), 32'd0);

        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        chk("start_clear_busy", 32'(busy_v), 32'd0);
        for (int u = 0; u < 3; u++) chk("start_clear_out", out_v[u], 32'd0);
        repeat (12) @(negedge clk);

        for (int u = 0; u < 3; u++) chk("sb_empty", 32'(sb[u].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
